branch_predictor: RTL
=====================

# branch_predictor

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters. It gives the fetch stage a same-cycle taken/target prediction for the current fetch PC. It is trained by resolved control transfers from the mem/branch stage and replaces the fixed-depth prediction path in fetch. It also keeps lookup and mispredict performance counters for the CSR unit.

## Interface
- ENTRIES, 16: table depth; power of two, ≥2; IDX = log2(ENTRIES)
- CTR_WIDTH, 2: direction counter width, ≥1
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- enable  in  1  0: prediction outputs forced 0, training continues
- bp__invalidate  in  1  clear all valid bits (fence.i)
- if_bp__req  in  1  fetch lookup this cycle
- if_bp__pc  in  32  fetch PC
- bp_if__predict_taken  out  1  predict taken
- bp_if__predict_target  out  32  predicted target; 0 when not taken
- mb_bp__update  in  1  resolved, non-flushed branch/jump in mem/branch
- mb_bp__pc  in  32  PC of resolved instruction
- mb_bp__taken  in  1  actual direction
- mb_bp__target  in  32  actual target
- mb_bp__mispredict  in  1  prediction carried down the pipe was wrong
- bp__lookup_count  out  32  lookups since reset
- bp__mispredict_count  out  32  mispredicts since reset

## Operation
- Index = pc[IDX+1:2]; tag = pc[31:IDX+2]; pc[1:0] ignored.
- Entry: valid, tag, target[31:0], ctr[CTR_WIDTH-1:0].
- Hit = valid && tag match. predict_taken = enable && if_bp__req && hit && ctr MSB. predict_target = predict_taken ? target : 0.
- Update, hit, taken: ctr saturating +1; target ← mb_bp__target.
- Update, hit, not taken: ctr saturating −1; target unchanged.
- Update, miss, taken: allocate (overwrite any alias): valid=1, tag, target, ctr = weakly taken (MSB=1, rest 0).
- Update, miss, not taken: no change.
- Invalidate: all valid ← 0; counters/targets not cleared. Invalidate and update in same cycle: invalidate wins, no allocation.
- lookup_count += 1 per cycle with if_bp__req. mispredict_count += 1 per cycle with mb_bp__update && mb_bp__mispredict. Both wrap at 2^32 without saturation.

## Timing
- Lookup is combinational from table state, with zero cycles of latency.
- Updates and invalidates commit on the posedge and are visible to lookups on the next cycle.
- A lookup and an update to the same index in the same cycle: the lookup sees pre-update state. There is no bypass.
- Asynchronous reset clears all valid bits, all counters and both perf counters immediately. Outputs go to 0 and stay 0 until the first allocation.
- Reset mid-operation discards any in-flight update.
- Counter widths: the increment saturates at all-ones and the decrement saturates at 0, with no wrap.

## Structure
- Shared header predict.vh holds:
  - entry field offsets;
  - the weakly-taken init value macro;
  - the index and tag slice macros, parametrised by IDX.
- Sub-module bp_sat_counter: width-parametrised saturating up/down next-value logic. It is instantiated once on the update path.
- Storage is flat register arrays. Valid bits are kept in a separate vector so invalidate takes one cycle.

## Test plan
- Reset, then lookup 0x100 → taken 0, target 0, both perf counters 0.
- Update pc 0x100, taken, target 0x80 → next cycle, lookup 0x100 gives taken 1 / target 0x80; lookup 0x140 (same index, different tag) gives taken 0.
- From weakly taken at 0x100:
  - 2× not-taken → ctr 00, predict 0;
  - 3× taken → ctr 11, predict 1;
  - 4th taken stays 11;
  - 1 not-taken → ctr 10, still predict 1.
- Allocate 0x140 taken, target 0x200 → 0x100 misses, 0x140 hits with 0x200. Set enable=0 → taken 0 while counts continue.
- Invalidate and update(0x100, taken) in the same cycle → all lookups miss next cycle.
- Assert rst_n=0 asynchronously mid-stream with a valid table and counters at 5/2 → outputs and counters 0 before the next clk edge.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the branch target buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package branch_predictor_pkg;

    localparam int BP_PC_W = 32;

    // Effect of one training beat on the entry it addresses.
    typedef enum logic [1:0] {
        UPD_NONE  = 2'd0,
        UPD_TRAIN = 2'd1,   // hit: move the counter, and on taken refresh the target
        UPD_ALLOC = 2'd2    // miss and taken: overwrite the slot
    } upd_act_e;

    // Invalidate has priority, so no allocation can happen in the same cycle.
    function automatic upd_act_e upd_action(input logic update,
                                            input logic inval,
                                            input logic hit,
                                            input logic taken);
        upd_act_e act;
        act = UPD_NONE;
        if (update && !inval) begin
            if (hit)        act = UPD_TRAIN;
            else if (taken) act = UPD_ALLOC;
        end
        return act;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up/down next-value logic for a direction counter.
// Latency: combinational, 0 cycles.
// Backpressure: none; the result is a pure function of the inputs.
// Ports: cur = present value; up = 1 to increment, 0 to decrement; nxt = next value.
module bp_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         up,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (up) begin
            if (cur != {W{1'b1}}) nxt = cur + W'(1);
        end else begin
            if (cur != '0) nxt = cur - W'(1);
        end
    end

endmodule

// File: rtl/predict.vh
`ifndef PREDICT_VH
`define PREDICT_VH
// Shared branch-target-buffer layout helpers.
// The entry word is packed as {tag, target[31:0], ctr}. The ctr field starts at bit 0.
`define BP_CTR_LSB        0
`define BP_TGT_LSB(cw)    (cw)
`define BP_TAG_LSB(cw)    ((cw) + 32)
// Weakly taken means the MSB is set and all other bits are clear.
`define BP_WEAK_TAKEN(cw) ((cw)'(1) << ((cw) - 1))
// Index and tag slices of a PC. Bits [1:0] are never part of either slice.
`define BP_IDX(pc, idx)   pc[(idx)+1:2]
`define BP_TAG(pc, idx)   pc[31:(idx)+2]
`endif

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and perf counters.
// Latency: the lookup is combinational (0 cycles); training and invalidate commit on the posedge.
// Backpressure: none; a lookup and an update are accepted every cycle.
// Ports: the if_bp__* inputs carry the fetch lookup, and bp_if__* is the prediction returned to fetch.
//        The mb_bp__* inputs are the resolved-branch training beat.
//        bp__invalidate clears every entry (fence.i).
//        bp__lookup_count and bp__mispredict_count go to the CSR unit.
`include "predict.vh"

module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int CTR_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        bp__invalidate,
    input  logic        if_bp__req,
    input  logic [31:0] if_bp__pc,
    output logic        bp_if__predict_taken,
    output logic [31:0] bp_if__predict_target,
    input  logic        mb_bp__update,
    input  logic [31:0] mb_bp__pc,
    input  logic        mb_bp__taken,
    input  logic [31:0] mb_bp__target,
    input  logic        mb_bp__mispredict,
    output logic [31:0] bp__lookup_count,
    output logic [31:0] bp__mispredict_count
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = BP_PC_W - IDX - 2;
    localparam int ENT_W = TAG_W + BP_PC_W + CTR_WIDTH;

    // Valid bits are kept apart from the entry words so that invalidate is a single vector clear.
    logic [ENTRIES-1:0] valid_q;
    logic [ENT_W-1:0]   ent_q [ENTRIES];

    // ---------------- lookup (fetch side) ----------------
    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [ENT_W-1:0] lk_ent;
    logic             lk_hit;

    assign lk_idx = `BP_IDX(if_bp__pc, IDX);
    assign lk_tag = `BP_TAG(if_bp__pc, IDX);
    assign lk_ent = ent_q[lk_idx];
    assign lk_hit = valid_q[lk_idx] &&
                    (lk_ent[`BP_TAG_LSB(CTR_WIDTH) +: TAG_W] == lk_tag);

    // This reads the registered table directly. A same-cycle update to the same index is not
    // visible here until the next cycle.
    assign bp_if__predict_taken  = enable && if_bp__req && lk_hit &&
                                   lk_ent[`BP_CTR_LSB + CTR_WIDTH - 1];
    assign bp_if__predict_target = bp_if__predict_taken ?
                                   lk_ent[`BP_TGT_LSB(CTR_WIDTH) +: BP_PC_W] : '0;

    // ---------------- training (mem/branch side) ----------------
    logic [IDX-1:0]       up_idx;
    logic [TAG_W-1:0]     up_tag;
    logic [ENT_W-1:0]     up_ent;
    logic                 up_hit;
    logic [CTR_WIDTH-1:0] up_ctr_nxt;
    logic [ENT_W-1:0]     up_wr_ent;
    upd_act_e             up_act;

    assign up_idx = `BP_IDX(mb_bp__pc, IDX);
    assign up_tag = `BP_TAG(mb_bp__pc, IDX);
    assign up_ent = ent_q[up_idx];
    assign up_hit = valid_q[up_idx] &&
                    (up_ent[`BP_TAG_LSB(CTR_WIDTH) +: TAG_W] == up_tag);
    assign up_act = upd_action(mb_bp__update, bp__invalidate, up_hit, mb_bp__taken);

    bp_sat_counter #(
        .W (CTR_WIDTH)
    ) u_sat_counter (
        .cur (up_ent[`BP_CTR_LSB +: CTR_WIDTH]),
        .up  (mb_bp__taken),
        .nxt (up_ctr_nxt)
    );

    always_comb begin
        up_wr_ent = up_ent;
        case (up_act)
            UPD_TRAIN: begin
                up_wr_ent[`BP_CTR_LSB +: CTR_WIDTH] = up_ctr_nxt;
                if (mb_bp__taken)
                    up_wr_ent[`BP_TGT_LSB(CTR_WIDTH) +: BP_PC_W] = mb_bp__target;
            end
            UPD_ALLOC: begin
                up_wr_ent[`BP_TAG_LSB(CTR_WIDTH) +: TAG_W]   = up_tag;
                up_wr_ent[`BP_TGT_LSB(CTR_WIDTH) +: BP_PC_W] = mb_bp__target;
                up_wr_ent[`BP_CTR_LSB +: CTR_WIDTH]           = `BP_WEAK_TAKEN(CTR_WIDTH);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q              <= '0;
            for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
            bp__lookup_count     <= '0;
            bp__mispredict_count <= '0;
        end else begin
            if (bp__invalidate)
                valid_q <= '0;
            else if (up_act == UPD_ALLOC)
                valid_q[up_idx] <= 1'b1;

            if (up_act != UPD_NONE)
                ent_q[up_idx] <= up_wr_ent;

            // Both perf counters wrap freely.
            if (if_bp__req)
                bp__lookup_count <= bp__lookup_count + 32'd1;
            if (mb_bp__update && mb_bp__mispredict)
                bp__mispredict_count <= bp__mispredict_count + 32'd1;
        end
    end

    // The byte-offset bits of both PCs are don't-care. Only the counter MSB matters for a lookup.
    logic unused_bits;
    assign unused_bits = ^{if_bp__pc[1:0], mb_bp__pc[1:0], lk_ent[CTR_WIDTH-1:0]};

endmodule
